// File: rtl/store_buffer.sv
// Store buffer: in-order queue of committed stores between the MEM stage and
// the data-memory write port, with combinational store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  input  logic [5:0]       st_instr_id,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  input  logic [5:0]       ld_instr_id,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  output logic             ld_stall,
  output logic             mem_wr_valid,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  output logic [3:0]       mem_wr_strb,
  input  logic             mem_wr_ready,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  // Instruction ids, mirroring instr_defines.vh
  localparam logic [5:0] INSTR_LB  = 6'd1;
  localparam logic [5:0] INSTR_LH  = 6'd2;
  localparam logic [5:0] INSTR_LW  = 6'd3;
  localparam logic [5:0] INSTR_LBU = 6'd4;
  localparam logic [5:0] INSTR_LHU = 6'd5;
  localparam logic [5:0] INSTR_SB  = 6'd6;
  localparam logic [5:0] INSTR_SH  = 6'd7;
  localparam logic [5:0] INSTR_SW  = 6'd8;

  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Access size code: 0 = not a memory access of this kind, 1 = byte, 2 = half, 3 = word
  function automatic logic [1:0] st_size(input logic [5:0] id);
    case (id)
      INSTR_SB: st_size = 2'd1;
      INSTR_SH: st_size = 2'd2;
      INSTR_SW: st_size = 2'd3;
      default:  st_size = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] ld_size(input logic [5:0] id);
    case (id)
      INSTR_LB, INSTR_LBU: ld_size = 2'd1;
      INSTR_LH, INSTR_LHU: ld_size = 2'd2;
      INSTR_LW:            ld_size = 2'd3;
      default:             ld_size = 2'd0;
    endcase
  endfunction

  // Byte-lane enables for an access; sub-size address bits are ignored
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd1:    lane_mask = 4'b0001 << a;
      2'd2:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      2'd3:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate the low-order store data across every lane it could occupy
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd1:    lane_data = {4{d[7:0]}};
      2'd2:    lane_data = {2{d[15:0]}};
      2'd3:    lane_data = d;
      default: lane_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    expand_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Entry storage and queue control
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [29:0]      waddr_q [DEPTH];
  logic [29:0]      waddr_d [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [3:0]       strb_q  [DEPTH];
  logic [3:0]       strb_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [1:0]       st_sz_s;
  logic             push_s;
  logic             pop_s;

  // Lookup datapath
  logic [3:0]       ld_mask_s;
  logic [PTR_W-1:0] lk_idx_s;
  logic             sel_found_s;
  logic [31:0]      sel_data_s;
  logic [3:0]       sel_strb_s;

  // Full/empty come from the occupancy count; head==tail is ambiguous on wrap
  assign st_ready     = (count_q != CNT_FULL);
  assign empty        = (count_q == CNT_ZERO);
  assign count        = count_q;
  assign mem_wr_valid = (count_q != CNT_ZERO);
  assign mem_wr_addr  = {waddr_q[head_q], 2'b00};
  assign mem_wr_data  = data_q[head_q];
  assign mem_wr_strb  = strb_q[head_q];

  // Next-state: enqueue at tail, drain at head, track occupancy
  always_comb begin
    st_sz_s = st_size(st_instr_id);
    push_s  = st_valid && st_ready && (st_sz_s != 2'd0);
    pop_s   = (count_q != CNT_ZERO) && mem_wr_ready;
    vld_d   = vld_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // head and tail never coincide while both push and pop are possible
    if (pop_s) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      vld_d[tail_q]   = 1'b1;
      waddr_d[tail_q] = st_addr[31:2];
      data_d[tail_q]  = lane_data(st_sz_s, st_data);
      strb_d[tail_q]  = lane_mask(st_sz_s, st_addr[1:0]);
      tail_d          = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear; clearing discards pending stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= {DEPTH{1'b0}};
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= 30'h0;
        data_q[i]  <= 32'h0000_0000;
        strb_q[i]  <= 4'h0;
      end
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  // Scan oldest-to-youngest so the last overlapping entry (youngest) wins
  always_comb begin
    ld_mask_s   = lane_mask(ld_size(ld_instr_id), ld_addr[1:0]);
    sel_found_s = 1'b0;
    sel_data_s  = 32'h0000_0000;
    sel_strb_s  = 4'h0;
    lk_idx_s    = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx_s = head_q + PTR_W'(k);
      if (vld_q[lk_idx_s] && (waddr_q[lk_idx_s] == ld_addr[31:2]) &&
          ((strb_q[lk_idx_s] & ld_mask_s) != 4'h0)) begin
        sel_found_s = 1'b1;
        sel_data_s  = data_q[lk_idx_s];
        sel_strb_s  = strb_q[lk_idx_s];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Forward when the youngest overlap covers the whole load, else request a stall
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = 32'h0000_0000;
    if (sel_found_s && ((ld_mask_s & ~sel_strb_s) == 4'h0)) begin
      ld_hit  = 1'b1;
      ld_data = sel_data_s & expand_mask(ld_mask_s);
    end else if (sel_found_s) begin
      ld_stall = 1'b1;
    end else begin
      ld_hit = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  localparam logic [5:0] NOP = 6'd0;
  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  logic             clk;
  logic             rst_n;
  logic             st_valid;
  logic [5:0]       st_instr_id;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_ready;
  logic [5:0]       ld_instr_id;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             ld_stall;
  logic             mem_wr_valid;
  logic [31:0]      mem_wr_addr;
  logic [31:0]      mem_wr_data;
  logic [3:0]       mem_wr_strb;
  logic             mem_wr_ready;
  logic [PTR_W:0]   count;
  logic             empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_instr_id(st_instr_id), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready),
    .ld_instr_id(ld_instr_id), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .mem_wr_ready(mem_wr_ready), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t mq[$];    // reference queue of pending stores, oldest first
  ent_t wlog[$];  // writes accepted by memory
  ent_t exp_w[$]; // writes expected by a directed scenario

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Access sizes in bytes; 0 means the id is not an access of that kind
  function automatic int st_bytes(input logic [5:0] id);
    if (id == SB) return 1;
    if (id == SH) return 2;
    if (id == SW) return 4;
    return 0;
  endfunction

  function automatic int ld_bytes(input logic [5:0] id);
    if (id == LB || id == LBU) return 1;
    if (id == LH || id == LHU) return 2;
    if (id == LW) return 4;
    return 0;
  endfunction

  // Naturally aligned lane window of `size` bytes containing the address
  function automatic logic [3:0] mask_of(input int size, input logic [1:0] a);
    logic [3:0] m;
    int lane;
    m = 4'h0;
    if (size != 0) begin
      lane = (int'(a) / size) * size;
      for (int i = 0; i < size; i++) m[lane + i] = 1'b1;
    end
    return m;
  endfunction

  function automatic ent_t enc(input logic [5:0] id, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int sz;
    sz     = st_bytes(id);
    e.wa   = a[31:2];
    e.strb = mask_of(sz, a[1:0]);
    for (int i = 0; i < 4; i++) e.data[8*i +: 8] = d[8*(i % sz) +: 8];
    return e;
  endfunction

  // Reference model update at each edge; reset empties it immediately
  logic m_push, m_pop;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_push = st_valid && (mq.size() < DEPTH) && (st_bytes(st_instr_id) != 0);
      m_pop  = (mq.size() != 0) && mem_wr_ready;
      if (m_pop) mq.delete(0);
      if (m_push) mq.push_back(enc(st_instr_id, st_addr, st_data));
    end
  end

  // Record every write the memory actually accepts
  ent_t lw_e;
  always @(posedge clk) begin
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      lw_e.wa   = mem_wr_addr[31:2];
      lw_e.data = mem_wr_data;
      lw_e.strb = mem_wr_strb;
      wlog.push_back(lw_e);
    end
  end

  // Per-cycle compare of all outputs against the reference queue
  ent_t       ce;
  logic       cfound, chit;
  logic [3:0] clm;
  logic [31:0] cdata;
  always @(negedge clk) begin
    chk("st_ready", st_ready, mq.size() < DEPTH);
    chk("count", 32'(count), mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("mem_wr_valid", mem_wr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("mem_wr_addr", mem_wr_addr, {mq[0].wa, 2'b00});
      chk("mem_wr_data", mem_wr_data, mq[0].data);
      chk("mem_wr_strb", 32'(mem_wr_strb), 32'(mq[0].strb));
    end
    clm    = mask_of(ld_bytes(ld_instr_id), ld_addr[1:0]);
    cfound = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!cfound && mq[i].wa == ld_addr[31:2] && (mq[i].strb & clm) != 4'h0) begin
        cfound = 1'b1;
        ce     = mq[i];
      end
    end
    chit  = cfound && ((clm & ~ce.strb) == 4'h0);
    cdata = 32'h0;
    if (chit) begin
      for (int b = 0; b < 4; b++) cdata[8*b +: 8] = clm[b] ? ce.data[8*b +: 8] : 8'h00;
    end
    chk("ld_hit", ld_hit, chit);
    chk("ld_stall", ld_stall, cfound && !chit);
    chk("ld_data", ld_data, cdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [5:0] id, input logic [31:0] a, input logic [31:0] d);
    st_valid    = 1'b1;
    st_instr_id = id;
    st_addr     = a;
    st_data     = d;
  endtask

  task automatic drain(input int budget);
    mem_wr_ready = 1'b1;
    for (int i = 0; i < budget && !empty; i++) tick();
    chk("drain_done", empty, 1'b1);
    mem_wr_ready = 1'b0;
  endtask

  logic [5:0] ids [9] = '{NOP, LB, LH, LW, LBU, LHU, SB, SH, SW};
  logic [5:0] sids [3] = '{SB, SH, SW};
  logic acc;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_instr_id = NOP; st_addr = 32'h0; st_data = 32'h0;
    ld_instr_id = LW; ld_addr = 32'h0; mem_wr_ready = 1'b0;
    tick(); tick();
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_wr_valid", mem_wr_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_ld_stall", ld_stall, 1'b0);
    chk("rst_ld_data", ld_data, 32'h0);
    rst_n = 1'b1;
    ld_instr_id = NOP;
    tick();

    // SW held at the port while memory is not ready
    drive_st(SW, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_valid", mem_wr_valid, 1'b1);
      chk("sw_addr", mem_wr_addr, 32'h0000_0100);
      chk("sw_strb", 32'(mem_wr_strb), 32'hF);
      chk("sw_data", mem_wr_data, 32'hDEAD_BEEF);
      tick();
    end
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    chk("sw_popped_empty", empty, 1'b1);

    // SB forwarding and partial-overlap stall
    drive_st(SB, 32'h0000_0203, 32'h0000_00AA);
    tick();
    st_valid = 1'b0;
    ld_instr_id = LBU; ld_addr = 32'h0000_0203; #1;
    chk("sb_lbu_hit", ld_hit, 1'b1);
    chk("sb_lbu_data", ld_data, 32'hAA00_0000);
    ld_instr_id = LW; ld_addr = 32'h0000_0200; #1;
    chk("sb_lw_stall", ld_stall, 1'b1);
    chk("sb_lw_hit", ld_hit, 1'b0);
    ld_instr_id = NOP;
    drain(20);

    // Same-cycle store and load are not forwarded; next cycle they are
    drive_st(SW, 32'h0000_0300, 32'h1234_5678);
    ld_instr_id = LW; ld_addr = 32'h0000_0300; #1;
    chk("same_cycle_no_hit", ld_hit, 1'b0);
    tick();
    st_valid = 1'b0;
    chk("next_cycle_hit", ld_hit, 1'b1);
    chk("next_cycle_data", ld_data, 32'h1234_5678);
    ld_instr_id = LH; ld_addr = 32'h0000_0302; #1;
    chk("lh_upper_data", ld_data, 32'h1234_0000);
    ld_instr_id = NOP;
    drain(20);

    // Youngest matching entry wins
    drive_st(SW, 32'h0000_0040, 32'h1111_1111); tick();
    drive_st(SW, 32'h0000_0040, 32'h2222_2222); tick();
    st_valid = 1'b0;
    ld_instr_id = LW; ld_addr = 32'h0000_0040; #1;
    chk("youngest_hit", ld_hit, 1'b1);
    chk("youngest_data", ld_data, 32'h2222_2222);
    ld_instr_id = NOP;
    drain(20);

    // Fill, drop when full, no same-cycle full bypass
    for (int i = 0; i < 4; i++) begin
      drive_st(SW, 32'h0000_0500 + 32'(4*i), 32'hA000_0000 + 32'(i));
      tick();
    end
    chk("full_st_ready", st_ready, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    drive_st(SW, 32'h0000_0600, 32'hBAD0_0000);
    tick();
    chk("full_drop_count", 32'(count), 32'd4);
    drive_st(SW, 32'h0000_0700, 32'hC0DE_0000);
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    chk("no_bypass_count", 32'(count), 32'd3);
    tick();
    st_valid = 1'b0;
    chk("accept_next_count", 32'(count), 32'd4);
    wlog.delete();
    drain(40);
    chk("fill_write_cnt", wlog.size(), 32'd4);
    if (wlog.size() == 4) chk("fill_last_addr", {wlog[3].wa, 2'b00}, 32'h0000_0700);

    // Ten stores under random memory back-pressure, checked in order
    wlog.delete();
    exp_w.delete();
    for (int s = 0; s < 10; ) begin
      drive_st(sids[$urandom_range(0, 2)], 32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom);
      mem_wr_ready = 1'($urandom_range(0, 1));
      acc = st_ready;
      if (acc) exp_w.push_back(enc(st_instr_id, st_addr, st_data));
      tick();
      if (acc) s++;
    end
    st_valid = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      mem_wr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    mem_wr_ready = 1'b0;
    chk("ten_empty", empty, 1'b1);
    chk("ten_write_cnt", wlog.size(), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      chk("ten_addr", 32'(wlog[i].wa), 32'(exp_w[i].wa));
      chk("ten_data", wlog[i].data, exp_w[i].data);
      chk("ten_strb", 32'(wlog[i].strb), 32'(exp_w[i].strb));
    end

    // Reset with pending stores discards them
    for (int i = 0; i < 3; i++) begin
      drive_st(SW, 32'h0000_0800 + 32'(4*i), 32'h5500_0000 + 32'(i));
      tick();
    end
    st_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", mem_wr_valid, 1'b0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", empty, 1'b1);
    wlog.delete();
    mem_wr_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_wr_ready = 1'b0;
    chk("rst_no_write", wlog.size(), 32'd0);

    // Randomized mix of stores, non-stores, lookups and back-pressure
    for (int c = 0; c < 600; c++) begin
      st_valid     = 1'($urandom_range(0, 1));
      st_instr_id  = ids[$urandom_range(0, 8)];
      st_addr      = 32'h0000_0040 + 32'($urandom_range(0, 15));
      st_data      = $urandom;
      ld_instr_id  = ids[$urandom_range(0, 8)];
      ld_addr      = 32'h0000_0040 + 32'($urandom_range(0, 15));
      mem_wr_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    st_valid = 1'b0;
    ld_instr_id = NOP;
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
